// File: rtl/tetris_pkg.sv
// Shared playfield geometry, score table and line-clear sequencer state encoding.
package tetris_pkg;

    localparam int ROWS    = 20;
    localparam int COLS    = 10;
    localparam int CELL_W  = 5;
    localparam int ROW_W   = COLS * CELL_W;
    localparam int ROW_AW  = $clog2(ROWS);
    localparam int CNT_W   = $clog2(ROWS + 1);
    localparam int SCORE_W = 11;

    localparam logic [CELL_W-1:0] CELL_EMPTY = '0;

    localparam logic [SCORE_W-1:0] SCORE_1 = 11'd40;
    localparam logic [SCORE_W-1:0] SCORE_2 = 11'd100;
    localparam logic [SCORE_W-1:0] SCORE_3 = 11'd300;
    localparam logic [SCORE_W-1:0] SCORE_4 = 11'd1200;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EV,
        FILL,
        DONE
    } lcs_state_e;

    // Anything beyond four lines scores as a tetris.
    function automatic logic [SCORE_W-1:0] score_for(input logic [CNT_W-1:0] n);
        case (n)
            CNT_W'(0): score_for = '0;
            CNT_W'(1): score_for = SCORE_1;
            CNT_W'(2): score_for = SCORE_2;
            CNT_W'(3): score_for = SCORE_3;
            default:   score_for = SCORE_4;
        endcase
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row test: a row is full when no cell holds the empty code.
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int N_CELLS   = COLS,
    parameter int CELL_BITS = CELL_W
) (
    input  logic [N_CELLS*CELL_BITS-1:0] row,
    output logic                         full
);

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (row[i*CELL_BITS +: CELL_BITS] == CELL_BITS'(CELL_EMPTY))
                full = 1'b0;
        end
    end

endmodule

// File: rtl/line_clear_sequencer.sv
// Bottom-up row-clear and compaction pass over the playfield map, run after each piece lock.
module line_clear_sequencer
    import tetris_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ROW_AW-1:0]  map_raddr,
    input  logic [ROW_W-1:0]   map_rdata,
    output logic [ROW_AW-1:0]  map_waddr,
    output logic [ROW_W-1:0]   map_wdata,
    output logic               map_we,
    output logic [CNT_W-1:0]   lines_cleared,
    output logic [SCORE_W-1:0] score_add
);

    lcs_state_e        state, state_nxt;
    logic [ROW_AW-1:0] rd, rd_nxt;
    logic [ROW_AW-1:0] wr, wr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              row_full;

    row_full_detect u_row_full (
        .row  (map_rdata),
        .full (row_full)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            rd            <= '0;
            wr            <= '0;
            cnt           <= '0;
            lines_cleared <= '0;
            score_add     <= '0;
        end else begin
            state <= state_nxt;
            rd    <= rd_nxt;
            wr    <= wr_nxt;
            cnt   <= cnt_nxt;
            // Results become visible together with the done pulse.
            if (state_nxt == DONE) begin
                lines_cleared <= cnt_nxt;
                score_add     <= score_for(cnt_nxt);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd;
        wr_nxt    = wr;
        cnt_nxt   = cnt;
        map_we    = 1'b0;
        map_wdata = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    rd_nxt    = ROW_AW'(ROWS - 1);
                    wr_nxt    = ROW_AW'(ROWS - 1);
                    cnt_nxt   = '0;
                    state_nxt = RD;
                end
            end

            RD: state_nxt = EV;

            EV: begin
                if (row_full) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    // A row that would land on itself needs no write.
                    if (wr != rd) begin
                        map_we    = 1'b1;
                        map_wdata = map_rdata;
                    end
                    if (wr != '0)
                        wr_nxt = wr - ROW_AW'(1);
                end

                if (rd == '0) begin
                    state_nxt = (cnt_nxt != '0) ? FILL : DONE;
                end else begin
                    rd_nxt    = rd - ROW_AW'(1);
                    state_nxt = RD;
                end
            end

            FILL: begin
                map_we = 1'b1;
                if (wr == '0)
                    state_nxt = DONE;
                else
                    wr_nxt = wr - ROW_AW'(1);
            end

            DONE: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RD) || (state == EV) || (state == FILL);
    assign done      = (state == DONE);
    assign map_raddr = rd;
    assign map_waddr = wr;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Directed bench for line_clear_sequencer with a synchronous-read row map model.
module tb_line_clear_sequencer;
    import tetris_pkg::*;

    logic               CLOCK_50;
    logic               RESET_N;
    logic               start;
    logic               busy;
    logic               done;
    logic [ROW_AW-1:0]  map_raddr;
    logic [ROW_W-1:0]   map_rdata;
    logic [ROW_AW-1:0]  map_waddr;
    logic [ROW_W-1:0]   map_wdata;
    logic               map_we;
    logic [CNT_W-1:0]   lines_cleared;
    logic [SCORE_W-1:0] score_add;

    line_clear_sequencer dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .map_raddr     (map_raddr),
        .map_rdata     (map_rdata),
        .map_waddr     (map_waddr),
        .map_wdata     (map_wdata),
        .map_we        (map_we),
        .lines_cleared (lines_cleared),
        .score_add     (score_add)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic [ROW_W-1:0]  mem     [ROWS];
    logic [ROW_W-1:0]  img     [ROWS];
    logic [ROW_W-1:0]  exp_map [ROWS];
    logic              ld_we;
    logic [ROW_AW-1:0] ld_addr;
    logic [ROW_W-1:0]  ld_data;
    int                wr_count   = 0;
    int                done_count = 0;

    // Map model: one row port, read data one cycle after address; bench load port has priority.
    always @(posedge CLOCK_50) begin
        map_rdata <= mem[map_raddr];
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end else if (map_we) begin
            mem[map_waddr] <= map_wdata;
            wr_count       <= wr_count + 1;
        end
        if (done)
            done_count <= done_count + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] full_row(input int seed);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < COLS; i++)
            r[i*CELL_W +: CELL_W] = CELL_W'(((seed + i) % 31) + 1);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] part_row(input int n, input int seed);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[i*CELL_W +: CELL_W] = CELL_W'(((seed + 3 * i) % 31) + 1);
        return r;
    endfunction

    function automatic bit row_is_full(input logic [ROW_W-1:0] r);
        for (int i = 0; i < COLS; i++)
            if (r[i*CELL_W +: CELL_W] == '0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < ROWS; i++) img[i] = '0;
    endtask

    // Reference compaction: surviving rows stack from the bottom, the rest are zero.
    task automatic build_expected();
        int w;
        for (int i = 0; i < ROWS; i++) exp_map[i] = '0;
        w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!row_is_full(img[r])) begin
                exp_map[w] = img[r];
                w--;
            end
        end
    endtask

    task automatic load_img();
        for (int i = 0; i < ROWS; i++) begin
            @(negedge CLOCK_50);
            ld_we   = 1'b1;
            ld_addr = ROW_AW'(i);
            ld_data = img[i];
        end
        @(negedge CLOCK_50);
        ld_we = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int exp_lines, input int exp_score,
                            input int exp_lat, input int exp_writes, input int extra_start);
        int w0, d0, cyc;
        bit seen;
        build_expected();
        load_img();
        w0 = wr_count;
        d0 = done_count;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        while (cyc < 200) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge CLOCK_50);
            #1;
            cyc++;
            start = (cyc == extra_start);
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " lines_cleared"}, 64'(lines_cleared), 64'(exp_lines));
        check({tag, " score_add"}, 64'(score_add), 64'(exp_score));
        @(posedge CLOCK_50);
        #1;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " lines_held"}, 64'(lines_cleared), 64'(exp_lines));
        repeat (extra_start > 0 ? 60 : 3) @(posedge CLOCK_50);
        #1;
        check({tag, " done_count"}, 64'(done_count - d0), 64'd1);
        check({tag, " write_count"}, 64'(wr_count - w0), 64'(exp_writes));
        for (int i = 0; i < ROWS; i++)
            check($sformatf("%s row%0d", tag, i), 64'(mem[i]), 64'(exp_map[i]));
    endtask

    initial begin
        RESET_N = 1'b0;
        start   = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst map_we", 64'(map_we), 64'd0);
        check("rst map_raddr", 64'(map_raddr), 64'd0);
        check("rst map_waddr", 64'(map_waddr), 64'd0);
        check("rst map_wdata", 64'(map_wdata), 64'd0);
        check("rst lines", 64'(lines_cleared), 64'd0);
        check("rst score", 64'(score_add), 64'd0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;

        // No full rows: nothing moves.
        clear_img();
        for (int r = 15; r < ROWS; r++) img[r] = part_row(r - 12, r);
        run_pass("none", 0, 0, 41, 0, 0);

        // Single bottom clear: everything shifts down by one.
        clear_img();
        img[19] = full_row(1);
        img[18] = part_row(7, 2);
        img[17] = part_row(3, 5);
        run_pass("one", 1, 40, 42, 20, 0);
        check("one row19_is_old18", 64'(mem[19]), 64'(part_row(7, 2)));
        check("one row18_is_old17", 64'(mem[18]), 64'(part_row(3, 5)));
        check("one row0_zero", 64'(mem[0]), 64'd0);

        // Tetris: four bottom rows cleared.
        clear_img();
        for (int r = 16; r < ROWS; r++) img[r] = full_row(r);
        img[15][CELL_W-1:0] = CELL_W'(1);
        run_pass("four", 4, 1200, 45, 20, 0);
        check("four row19_is_0x1", 64'(mem[19]), 64'h1);
        check("four row3_zero", 64'(mem[3]), 64'd0);

        // Split clears with survivors in between.
        clear_img();
        img[19] = full_row(4);
        img[18] = part_row(9, 6);
        img[17] = full_row(8);
        img[16] = part_row(2, 11);
        run_pass("split", 2, 100, 43, 20, 0);
        check("split row19_is_old18", 64'(mem[19]), 64'(part_row(9, 6)));
        check("split row18_is_old16", 64'(mem[18]), 64'(part_row(2, 11)));

        // One empty cell keeps the row.
        clear_img();
        for (int i = 0; i < COLS - 1; i++) img[19][i*CELL_W +: CELL_W] = 5'd31;
        run_pass("gap", 0, 0, 41, 0, 0);
        check("gap row19_kept", 64'(mem[19]), 64'(img[19]));

        // Start during a pass must be ignored.
        clear_img();
        img[19] = full_row(1);
        img[18] = part_row(7, 2);
        run_pass("restart", 1, 40, 42, 20, 5);

        // Reset in the middle of a pass, then a clean pass.
        clear_img();
        for (int r = 16; r < ROWS; r++) img[r] = full_row(r);
        img[15] = part_row(4, 9);
        load_img();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst map_we", 64'(map_we), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        run_pass("after_rst", 4, 1200, 45, 20, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
